// File: rtl/sevenseg_pkg.sv
// Shared 7-segment definitions: segment bit positions, hex glyph table and capture FSM states.
// Used by both the capture (decode) side and the display (encode) side.
package sevenseg_pkg;

  localparam int unsigned SEG_W = 8;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned PAT_W = 7;
  localparam int unsigned HEX_N = 16;

  // Segment bit positions within an 8-bit segment bus
  typedef enum int unsigned {
    SEG_A  = 0,
    SEG_B  = 1,
    SEG_C  = 2,
    SEG_D  = 3,
    SEG_E  = 4,
    SEG_F  = 5,
    SEG_G  = 6,
    SEG_DP = 7
  } seg_bit_e;

  // Glyph for nibble n sits at HEX_TABLE[n]; listed from F down to 0
  localparam logic [HEX_N-1:0][PAT_W-1:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational reverse lookup of a 7-segment glyph to its hex nibble.
// Patterns outside the glyph table (including blank) report legal_c = 0.
module seg_to_hex
  import sevenseg_pkg::*;
(
  input  logic [PAT_W-1:0] pattern,
  output logic             legal_c,
  output logic [NIB_W-1:0] nibble_c
);

  always_comb begin
    legal_c  = 1'b0;
    nibble_c = '0;
    for (int unsigned i = 0; i < HEX_N; i++) begin
      if (pattern == HEX_TABLE[i]) begin
        legal_c  = 1'b1;
        nibble_c = NIB_W'(i);
      end
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Receive side of a multiplexed 7-segment display: waits for each digit's pattern to settle and
// decodes it back to hex. Define SEVENSEG_ERR_CNT_EN to add the saturating err_count output.
module sevenseg_capture #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          seg_in,
  input  logic [DIGITS-1:0]   an_in,
  output logic [4*DIGITS-1:0] digits_out,
  output logic [DIGITS-1:0]   dp_out,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                bad_pattern,
  output logic                frame_done
`ifdef SEVENSEG_ERR_CNT_EN
  ,
  output logic [7:0]          err_count
`endif
);
  import sevenseg_pkg::*;

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IN_W  = DIGITS + SEG_W;
  localparam logic [IN_W-1:0]  RAW_IDLE = {IN_W{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  logic [1:0]        rst_pipe;
  logic              rst_core_n;
  logic [IN_W-1:0]   sync1_q, sync2_q;
  logic [IN_W-1:0]   sample_c;
  logic [DIGITS-1:0] samp_an_c;
  logic              onehot_c, match_c;
  logic [IN_W-1:0]   lat_q;
  logic [DIGITS-1:0] lat_an_c;
  logic [CNT_W-1:0]  cnt_q;
  logic              capture_q;
  state_t            state_q, state_nxt;
  logic              latch_c, cnt_inc_c, cnt_clr_c, capture_c;
  logic              legal_c;
  logic [NIB_W-1:0]  nibble_c;
  logic [DIGITS-1:0] seen_q;

  // Reset asserts asynchronously, releases on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_core_n = rst_pipe[1];

  // Two-flop synchroniser; reset to the inactive bus level so nothing looks driven
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= {an_in, seg_in};
      sync2_q <= sync1_q;
    end
  end

  assign sample_c  = sync2_q ^ RAW_IDLE;
  assign samp_an_c = sample_c[IN_W-1:SEG_W];
  assign onehot_c  = (samp_an_c != '0) && ((samp_an_c & (samp_an_c - DIGITS'(1))) == '0);
  assign match_c   = (sample_c == lat_q);
  assign lat_an_c  = lat_q[IN_W-1:SEG_W];

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) state_q <= IDLE;
    else             state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (onehot_c) state_nxt = TRACK;
      TRACK: begin
        if (match_c) begin
          if (cnt_q == CNT_LAST) state_nxt = HOLD;
        end else if (!onehot_c) begin
          state_nxt = IDLE;
        end
      end
      HOLD:    if (!match_c) state_nxt = onehot_c ? TRACK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    latch_c   = 1'b0;
    cnt_inc_c = 1'b0;
    cnt_clr_c = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      IDLE: latch_c = onehot_c;
      TRACK, HOLD: begin
        if (match_c) begin
          cnt_inc_c = 1'b1;
          capture_c = (state_q == TRACK) && (cnt_q == CNT_LAST);
        end else begin
          latch_c   = onehot_c;
          cnt_clr_c = !onehot_c;
        end
      end
      default: ;
    endcase
  end

  // Latched pattern and saturating stability counter
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      lat_q     <= '0;
      cnt_q     <= '0;
      capture_q <= 1'b0;
    end else begin
      capture_q <= capture_c;
      if (latch_c) begin
        lat_q <= sample_c;
        cnt_q <= CNT_W'(1);
      end else if (cnt_clr_c) begin
        cnt_q <= '0;
      end else if (cnt_inc_c && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  seg_to_hex u_dec (
    .pattern  (lat_q[SEG_G:SEG_A]),
    .legal_c  (legal_c),
    .nibble_c (nibble_c)
  );

  // A capture on the frame_done cycle already belongs to the next frame
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      digits_out  <= '0;
      dp_out      <= '0;
      digit_valid <= '0;
      seen_q      <= '0;
      bad_pattern <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      bad_pattern <= capture_q && !legal_c;
      frame_done  <= &seen_q;
      seen_q      <= ((&seen_q) ? '0 : seen_q) | ((capture_q && legal_c) ? lat_an_c : '0);
      for (int unsigned k = 0; k < DIGITS; k++) begin
        if (capture_q && legal_c && lat_an_c[k]) begin
          digits_out[4*k +: 4] <= nibble_c;
          dp_out[k]            <= lat_q[SEG_DP];
          digit_valid[k]       <= 1'b1;
        end
      end
    end
  end

`ifdef SEVENSEG_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n)                                 err_count <= '0;
    else if (capture_q && !legal_c && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: directed scenarios plus random scans, with an active-high and an
// active-low instance fed the same logical stream and compared each cycle to a run-length model.
module tb_sevenseg_capture;

  localparam int STABLE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_h;
  logic [3:0]  an_h;
  logic [7:0]  seg_l;
  logic [3:0]  an_l;
  logic [15:0] dig_h, dig_l;
  logic [3:0]  dp_h, dp_l, val_h, val_l;
  logic        badp_h, badp_l, frm_h, frm_l;
`ifdef SEVENSEG_ERR_CNT_EN
  logic [7:0]  err_h, err_l;
`endif

  assign seg_l = ~seg_h;
  assign an_l  = ~an_h;

  always #5 clk = ~clk;

  sevenseg_capture #(.DIGITS(4), .STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_h), .an_in(an_h),
    .digits_out(dig_h), .dp_out(dp_h), .digit_valid(val_h),
    .bad_pattern(badp_h), .frame_done(frm_h)
`ifdef SEVENSEG_ERR_CNT_EN
    , .err_count(err_h)
`endif
  );

  sevenseg_capture #(.DIGITS(4), .STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_l), .an_in(an_l),
    .digits_out(dig_l), .dp_out(dp_l), .digit_valid(val_l),
    .bad_pattern(badp_l), .frame_done(frm_l)
`ifdef SEVENSEG_ERR_CNT_EN
    , .err_count(err_l)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Glyph -> {legal, nibble}
  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    case (p)
      7'h3F: return 5'h10; 7'h06: return 5'h11; 7'h5B: return 5'h12; 7'h4F: return 5'h13;
      7'h66: return 5'h14; 7'h6D: return 5'h15; 7'h7D: return 5'h16; 7'h07: return 5'h17;
      7'h7F: return 5'h18; 7'h6F: return 5'h19; 7'h77: return 5'h1A; 7'h7C: return 5'h1B;
      7'h39: return 5'h1C; 7'h5E: return 5'h1D; 7'h79: return 5'h1E; 7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  // Reference model: a capture fires when a run of identical one-hot samples reaches STABLE
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_valid, m_seen;
  logic        m_bad, m_frame;
  int          m_err;
  logic [11:0] d1, d2, cur, prev_s, pend_s;
  int          run;
  logic        pend;
  logic [4:0]  dec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_digits = '0; m_dp = '0; m_valid = '0; m_seen = '0;
      m_bad = 1'b0; m_frame = 1'b0; m_err = 0;
      d1 = '0; d2 = '0; prev_s = '0; run = 0; pend = 1'b0; pend_s = '0;
    end else begin
      m_bad = 1'b0;
      m_frame = 1'b0;
      if (m_seen == 4'hF) begin
        m_frame = 1'b1;
        m_seen  = '0;
      end
      if (pend) begin
        dec = ref_decode(pend_s[6:0]);
        if (dec[4]) begin
          for (int k = 0; k < 4; k++) begin
            if (pend_s[8+k]) begin
              m_digits[4*k +: 4] = dec[3:0];
              m_dp[k]    = pend_s[7];
              m_valid[k] = 1'b1;
              m_seen[k]  = 1'b1;
            end
          end
        end else begin
          m_bad = 1'b1;
          if (m_err < 255) m_err++;
        end
      end
      pend = 1'b0;
      cur = d2;
      d2  = d1;
      d1  = {an_h, seg_h};
      if (run > 0 && cur == prev_s) begin
        if (run < 100000) run++;
      end else begin
        run = 1;
      end
      prev_s = cur;
      if ($countones(cur[11:8]) == 1 && run == STABLE) begin
        pend   = 1'b1;
        pend_s = cur;
      end
    end
  end

  logic chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("h_digits", 32'(dig_h), 32'(m_digits));
      check("l_digits", 32'(dig_l), 32'(m_digits));
      check("h_dp", 32'(dp_h), 32'(m_dp));
      check("l_dp", 32'(dp_l), 32'(m_dp));
      check("h_valid", 32'(val_h), 32'(m_valid));
      check("l_valid", 32'(val_l), 32'(m_valid));
      check("h_bad", 32'(badp_h), 32'(m_bad));
      check("l_bad", 32'(badp_l), 32'(m_bad));
      check("h_frame", 32'(frm_h), 32'(m_frame));
      check("l_frame", 32'(frm_l), 32'(m_frame));
`ifdef SEVENSEG_ERR_CNT_EN
      check("h_err", 32'(err_h), 32'(m_err));
      check("l_err", 32'(err_l), 32'(m_err));
`endif
    end
  end

  int n_badp, n_frame, upd_cyc;

  // Drive a value, run n cycles, count pulses and note the first cycle the digit outputs move
  task automatic apply(input logic [3:0] a, input logic [7:0] s, input int n);
    logic [15:0] d0;
    logic [3:0]  v0;
    @(negedge clk);
    an_h  = a;
    seg_h = s;
    d0 = dig_h;
    v0 = val_h;
    upd_cyc = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      n_badp  += int'(badp_h);
      n_frame += int'(frm_h);
      if (upd_cyc == 0 && (dig_h != d0 || val_h != v0)) upd_cyc = i;
    end
  endtask

  logic [6:0] enc_tab [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    enc_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst_n = 1'b0;
    an_h  = '0;
    seg_h = '0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_digits", 32'(dig_h), 32'h0);
    check("rst_valid", 32'(val_l), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single digit settles: update 2 + 16 + 1 cycles after the input edge
    n_badp = 0; n_frame = 0;
    apply(4'b0001, 8'h06, 40);
    check("t1_latency", 32'(upd_cyc), 32'd19);
    check("t1_digit", 32'(dig_h[3:0]), 32'h1);
    check("t1_valid", 32'(val_h), 32'b0001);

    // Pattern changes before settling: only the second value is captured
    apply(4'b0010, 8'h06, 10);
    check("t2_nocap", 32'(upd_cyc), 32'd0);
    apply(4'b0010, 8'h5B, 30);
    check("t2_latency", 32'(upd_cyc), 32'd19);
    check("t2_digit", 32'(dig_h[7:4]), 32'h2);

    // Two anodes hot: never tracked
    n_badp = 0; n_frame = 0;
    apply(4'b0011, 8'h7F, 40);
    check("t3_noupd", 32'(upd_cyc), 32'd0);
    check("t3_pulses", 32'(n_badp + n_frame), 32'd0);

    // Illegal glyph: one bad_pattern pulse, digit untouched
    n_badp = 0;
    apply(4'b0100, 8'h49, 20);
    check("t4_badcnt", 32'(n_badp), 32'd1);
    check("t4_noupd", 32'(upd_cyc), 32'd0);
    check("t4_valid2", 32'(val_h[2]), 32'd0);
`ifdef SEVENSEG_ERR_CNT_EN
    check("t4_errcnt", 32'(err_h), 32'd1);
`endif

    // Scan F,E,d,C with dp on digit 1
    n_frame = 0;
    apply(4'b0001, 8'h71, 20);
    apply(4'b0010, 8'hF9, 20);
    apply(4'b0100, 8'h5E, 20);
    apply(4'b1000, 8'h39, 20);
    apply(4'b0000, 8'h00, 4);
    check("t5_digits", 32'(dig_h), 32'hCDEF);
    check("t5_dp", 32'(dp_h), 32'b0010);
    check("t5_frames", 32'(n_frame), 32'd1);

    // Random scans mixing legal, illegal, blank and non-one-hot anodes
    for (int i = 0; i < 150; i++) begin
      logic [3:0] a;
      logic [7:0] s;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70)      a = 4'(1 << $urandom_range(0, 3));
      else if (r < 85) a = 4'h0;
      else             a = 4'($urandom);
      r = int'($urandom_range(0, 99));
      if (r < 75)      s = {1'($urandom), enc_tab[$urandom_range(0, 15)]};
      else if (r < 85) s = 8'h00;
      else             s = 8'($urandom);
      apply(a, s, int'($urandom_range(1, 24)));
    end
    apply(4'b0000, 8'h00, 6);

    // Reset mid-track clears outputs immediately; digit is re-earned afterwards
    apply(4'b0001, 8'h6D, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_dig_h", 32'(dig_h), 32'h0);
    check("t6_rst_dig_l", 32'(dig_l), 32'h0);
    check("t6_rst_val", 32'(val_l), 32'h0);
    an_h  = '0;
    seg_h = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    apply(4'b0001, 8'h6D, 25);
    check("t6_digit_h", 32'(dig_h[3:0]), 32'h5);
    check("t6_digit_l", 32'(dig_l[3:0]), 32'h5);
    check("t6_valid", 32'(val_l), 32'b0001);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
